// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_sb
//  Description : Parametrised register file with write-through bypass, a
//                per-register pending scoreboard and a sequential sweep-clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              CLK_RegFile,
   input  logic              RST_RegFile,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD3,
   input  logic              WE3,
   input  logic              ISS_En,
   input  logic [ADDR_W-1:0] ISS_Reg,
   input  logic              CLR_Start,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic              Pend1,
   output logic              Pend2,
   output logic              CLR_Busy,
   output logic              Err_WAW
);

   localparam int                c_NREG     = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] c_LAST_IDX = '1;
   localparam logic [0:0]        c_S_IDLE   = 1'b0;
   localparam logic [0:0]        c_S_CLEAR  = 1'b1;

   logic [0:0]        r_state;
   logic [0:0]        w_state_next;
   logic [ADDR_W-1:0] r_idx;
   logic [DATA_W-1:0] r_regs [c_NREG];
   logic [c_NREG-1:0] r_pend;
   logic              r_err_waw;

   logic w_idle;
   logic w_busy;
   logic w_wr_ok;
   logic w_iss_ok;
   logic w_clr_go;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK_RegFile or negedge RST_RegFile) begin
      if (!RST_RegFile) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_S_IDLE:  if (CLR_Start)            w_state_next = c_S_CLEAR;
         c_S_CLEAR: if (r_idx == c_LAST_IDX)  w_state_next = c_S_IDLE;
         default:                             w_state_next = c_S_IDLE;
      endcase
   end

   always_comb begin
      w_idle = 1'b0;
      w_busy = 1'b0;
      case (r_state)
         c_S_IDLE:  w_idle = 1'b1;
         c_S_CLEAR: w_busy = 1'b1;
         default:   w_idle = 1'b1;
      endcase
   end

   // Writes and issues are only honoured while no sweep is running.
   assign w_wr_ok  = WE3    && w_idle && !((ZERO_REG != 0) && (A3 == '0));
   assign w_iss_ok = ISS_En && w_idle && !((ZERO_REG != 0) && (ISS_Reg == '0));
   assign w_clr_go = w_idle && CLR_Start;

   // ---------------------------------------------------------------- sweep index
   always_ff @(posedge CLK_RegFile or negedge RST_RegFile) begin
      if (!RST_RegFile) begin
         r_idx <= '0;
      end else if (w_clr_go) begin
         r_idx <= '0;
      end else if (w_busy) begin
         r_idx <= r_idx + ADDR_W'(1);
      end
   end

   // ---------------------------------------------------------------- storage
   always_ff @(posedge CLK_RegFile or negedge RST_RegFile) begin
      if (!RST_RegFile) begin
         for (int i = 0; i < c_NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_busy) begin
         r_regs[r_idx] <= '0;
      end else if (w_wr_ok) begin
         r_regs[A3] <= WD3;
      end
   end

   // ---------------------------------------------------------------- scoreboard
   // The set is applied after the clear so a same-register issue wins.
   always_ff @(posedge CLK_RegFile or negedge RST_RegFile) begin
      if (!RST_RegFile) begin
         r_pend <= '0;
      end else if (w_clr_go) begin
         r_pend <= '0;
      end else begin
         if (w_wr_ok) begin
            r_pend[A3] <= 1'b0;
         end
         if (w_iss_ok) begin
            r_pend[ISS_Reg] <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK_RegFile or negedge RST_RegFile) begin
      if (!RST_RegFile) begin
         r_err_waw <= 1'b0;
      end else if (w_iss_ok && r_pend[ISS_Reg] && !(w_wr_ok && (A3 == ISS_Reg))) begin
         r_err_waw <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- read ports
   logic [ADDR_W-1:0] w_ra [2];
   logic [DATA_W-1:0] w_rd [2];
   logic [1:0]        w_pd;

   assign w_ra[0] = A1;
   assign w_ra[1] = A2;

   for (genvar gp = 0; gp < 2; gp++) begin : g_rd_port
      logic w_zero_sel;
      logic w_byp;

      assign w_zero_sel = (ZERO_REG != 0) && (w_ra[gp] == '0);
      assign w_byp      = w_wr_ok && (w_ra[gp] == A3);

      // Reset gating keeps the bypass path from leaking WD3 while reset is held.
      assign w_rd[gp] = (!RST_RegFile || w_zero_sel) ? '0 :
                        w_byp                        ? WD3 : r_regs[w_ra[gp]];
      assign w_pd[gp] = RST_RegFile && r_pend[w_ra[gp]] && !(WE3 && (A3 == w_ra[gp]));
   end

   assign RD1      = w_rd[0];
   assign RD2      = w_rd[1];
   assign Pend1    = w_pd[0];
   assign Pend2    = w_pd[1];
   assign CLR_Busy = w_busy;
   assign Err_WAW  = r_err_waw;

endmodule
`default_nettype wire

// File: tb/tb_register_file_sb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_register_file_sb
//  Description : Scoreboard bench for register_file_sb against an array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_sb;

   typedef struct {
      logic        rst;
      logic [4:0]  a1, a2, a3, isr;
      logic [31:0] wd;
      logic        we, iss, clr;
   } stim_t;

   typedef struct {
      logic [31:0] rd1, rd2;
      logic        p1, p2, busy, err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  A1 = '0, A2 = '0, A3 = '0, ISS_Reg = '0;
   logic [31:0] WD3 = '0;
   logic        WE3 = 1'b0, ISS_En = 1'b0, CLR_Start = 1'b0;
   logic [31:0] RD1, RD2;
   logic        Pend1, Pend2, CLR_Busy, Err_WAW;

   register_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
      .CLK_RegFile(clk), .RST_RegFile(rst_n),
      .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
      .ISS_En(ISS_En), .ISS_Reg(ISS_Reg), .CLR_Start(CLR_Start),
      .RD1(RD1), .RD2(RD2), .Pend1(Pend1), .Pend2(Pend2),
      .CLR_Busy(CLR_Busy), .Err_WAW(Err_WAW)
   );

   always #5 clk = ~clk;

   // Reference model: plain arrays plus a countdown for the sweep.
   logic [31:0] mreg [32];
   bit          mpend [32];
   bit          merr;
   int          left, pos;

   exp_t q[$];
   event sample_ev;
   int   compared = 0;
   int   mismatched = 0;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         mreg[i]  = '0;
         mpend[i] = 1'b0;
      end
      merr = 1'b0;
      left = 0;
      pos  = 0;
   endfunction

   function automatic logic [31:0] m_rd(logic [4:0] a, stim_t st);
      if (a == 0) return '0;
      if (st.we && left == 0 && st.a3 == a) return st.wd;
      return mreg[a];
   endfunction

   function automatic logic m_pd(logic [4:0] a, stim_t st);
      return mpend[a] && !(st.we && st.a3 == a);
   endfunction

   function automatic exp_t model_exp(stim_t st);
      exp_t e;
      if (!st.rst) begin
         e.rd1 = '0; e.rd2 = '0; e.p1 = 1'b0; e.p2 = 1'b0; e.busy = 1'b0; e.err = 1'b0;
      end else begin
         e.rd1  = m_rd(st.a1, st);
         e.rd2  = m_rd(st.a2, st);
         e.p1   = m_pd(st.a1, st);
         e.p2   = m_pd(st.a2, st);
         e.busy = (left > 0);
         e.err  = merr;
      end
      return e;
   endfunction

   function automatic void model_edge(stim_t st);
      if (!st.rst) begin
         model_reset();
      end else if (left > 0) begin
         mreg[pos] = '0;
         pos++;
         left--;
      end else begin
         if (st.iss && st.isr != 0 && mpend[st.isr] && !(st.we && st.a3 == st.isr)) merr = 1'b1;
         if (st.we && st.a3 != 0) begin
            mreg[st.a3]  = st.wd;
            mpend[st.a3] = 1'b0;
         end
         if (st.iss && st.isr != 0) mpend[st.isr] = 1'b1;
         if (st.clr) begin
            for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
            left = 32;
            pos  = 0;
         end
      end
   endfunction

   function automatic stim_t nop();
      stim_t st;
      st.rst = 1'b1; st.a1 = '0; st.a2 = '0; st.a3 = '0; st.isr = '0;
      st.wd = '0; st.we = 1'b0; st.iss = 1'b0; st.clr = 1'b0;
      return st;
   endfunction

   // Inputs change on the falling edge; an async reset therefore lands off-edge.
   task automatic step(input stim_t st);
      @(negedge clk);
      rst_n = st.rst; A1 = st.a1; A2 = st.a2; A3 = st.a3; WD3 = st.wd;
      WE3 = st.we; ISS_En = st.iss; ISS_Reg = st.isr; CLR_Start = st.clr;
      if (!st.rst) model_reset();
      #1;
      q.push_back(model_exp(st));
      ->sample_ev;
      @(posedge clk);
      model_edge(st);
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", n, act, exp, $time);
      end
   endtask

   // Monitor: pops the oldest expectation whenever a stimulus cycle is presented.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         #1;
         if (q.size() == 0) begin
            mismatched++;
            $display("FAIL queue_empty: got no expectation, expected one");
         end else begin
            e = q.pop_front();
            chk("RD1", RD1, e.rd1);
            chk("RD2", RD2, e.rd2);
            chk("Pend1", {31'b0, Pend1}, {31'b0, e.p1});
            chk("Pend2", {31'b0, Pend2}, {31'b0, e.p2});
            chk("CLR_Busy", {31'b0, CLR_Busy}, {31'b0, e.busy});
            chk("Err_WAW", {31'b0, Err_WAW}, {31'b0, e.err});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      stim_t s;
      model_reset();

      // Reset held: bypass-looking inputs must not leak.
      for (int i = 0; i < 2; i++) begin
         s = nop(); s.rst = 1'b0; s.we = 1'b1; s.a3 = 5; s.a1 = 5; s.wd = 32'h1234_5678;
         step(s);
      end

      // Write / read / bypass
      s = nop(); s.we = 1'b1; s.a3 = 5; s.wd = 32'hDEAD_BEEF; s.a2 = 5; step(s);
      s = nop(); s.a1 = 5; step(s);

      // Zero register
      s = nop(); s.we = 1'b1; s.a3 = 0; s.wd = 32'hFFFF_FFFF; s.a1 = 0; step(s);
      s = nop(); s.a1 = 0; step(s);
      s = nop(); s.iss = 1'b1; s.isr = 0; s.a1 = 0; step(s);
      s = nop(); s.iss = 1'b1; s.isr = 0; s.a1 = 0; step(s);
      s = nop(); s.a1 = 0; step(s);

      // Scoreboard set / clear / same-edge set wins
      s = nop(); s.iss = 1'b1; s.isr = 7; s.a1 = 7; step(s);
      s = nop(); s.a1 = 7; step(s);
      s = nop(); s.we = 1'b1; s.a3 = 7; s.wd = 32'h77; s.a1 = 7; step(s);
      s = nop(); s.a1 = 7; step(s);
      s = nop(); s.iss = 1'b1; s.isr = 9; s.we = 1'b1; s.a3 = 9; s.wd = 32'h99; s.a1 = 9; step(s);
      s = nop(); s.a1 = 9; s.a2 = 9; step(s);
      s = nop(); s.iss = 1'b1; s.isr = 10; s.we = 1'b1; s.a3 = 9; s.wd = 32'h9A; s.a1 = 9; s.a2 = 10; step(s);
      s = nop(); s.a1 = 9; s.a2 = 10; step(s);

      // WAW: double issue to reg 3, sticky through writeback
      s = nop(); s.iss = 1'b1; s.isr = 3; s.a1 = 3; step(s);
      s = nop(); s.iss = 1'b1; s.isr = 3; s.a1 = 3; step(s);
      s = nop(); s.a1 = 3; step(s);
      s = nop(); s.we = 1'b1; s.a3 = 3; s.wd = 32'h33; s.a1 = 3; step(s);
      s = nop(); s.a1 = 3; step(s);

      // Sweep clear with a second start, a dropped write and a dropped issue
      for (int i = 1; i < 32; i++) begin
         s = nop(); s.we = 1'b1; s.a3 = 5'(i); s.wd = $urandom | 32'h1; s.a1 = 5'(i); step(s);
      end
      s = nop(); s.iss = 1'b1; s.isr = 4; s.a1 = 4; step(s);
      s = nop(); s.clr = 1'b1; s.a1 = 4; step(s);
      for (int k = 0; k < 36; k++) begin
         s = nop(); s.a1 = 4; s.a2 = 5'(k);
         if (k == 5) begin s.we = 1'b1; s.a3 = 20; s.wd = 32'hCAFE_F00D; s.a2 = 20; end
         if (k == 7) begin s.iss = 1'b1; s.isr = 12; s.a2 = 12; end
         if (k == 9) s.clr = 1'b1;
         step(s);
      end
      for (int i = 0; i < 16; i++) begin
         s = nop(); s.a1 = 5'(2*i); s.a2 = 5'(2*i+1); step(s);
      end

      // Async reset mid-sweep
      for (int i = 1; i < 8; i++) begin
         s = nop(); s.we = 1'b1; s.a3 = 5'(i); s.wd = 32'hA000_0000 + i; step(s);
      end
      s = nop(); s.clr = 1'b1; step(s);
      for (int k = 0; k < 12; k++) begin
         s = nop(); s.a1 = 5'(k); s.a2 = 3; step(s);
      end
      s = nop(); s.rst = 1'b0; s.we = 1'b1; s.a3 = 3; s.a1 = 3; s.a2 = 3; s.wd = 32'h5555; step(s);
      s = nop(); s.rst = 1'b0; s.a1 = 3; step(s);
      s = nop(); s.we = 1'b1; s.a3 = 6; s.wd = 32'h0BAD_CAFE; s.a2 = 6; step(s);
      s = nop(); s.a1 = 6; s.a2 = 3; step(s);

      // Randomised traffic concentrated on a few registers to provoke hazards
      for (int n = 0; n < 1500; n++) begin
         s = nop();
         s.rst = ($urandom_range(0, 399) != 0);
         s.a1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         s.a2  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         s.a3  = 5'($urandom_range(0, 7));
         s.isr = 5'($urandom_range(0, 7));
         s.wd  = $urandom;
         s.we  = $urandom_range(0, 1) == 1;
         s.iss = ($urandom_range(0, 3) == 0);
         s.clr = ($urandom_range(0, 199) == 0);
         step(s);
      end

      @(negedge clk);
      #5;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
